// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial-to-parallel receiver, single SCLK domain.
// Samples LRCK/SDATA on the rising SCLK edge and presents one left/right word
// pair per stereo frame with a one-cycle pvalid_out strobe.
// Optional build macro I2S_RX_FRAME_ERR_EN adds frame_err_out, which pulses when
// a committed slot length differs from PDATA_WIDTH.
//
// state     | meaning
// WAIT_SYNC | out of sync; waiting for a 1->0 LRCK boundary (left slot next)
// LEFT      | capturing a left slot; a rising boundary commits it
// RIGHT     | capturing a right slot; a falling boundary commits the frame
module i2s_rx #(
    parameter  int PDATA_WIDTH = 32,
    localparam int CNT_WIDTH   = $clog2(PDATA_WIDTH) + 2
) (
    input  logic                   sclk_in,
    input  logic                   rst,
    input  logic                   lrck_in,
    input  logic                   sdata_in,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   pvalid_out
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    output logic                   frame_err_out
`endif
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    localparam logic [PDATA_WIDTH-1:0] MSB_MASK = {1'b1, {(PDATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = '1;

    state_t                 state_q, state_d;
    logic                   lrck_d1_q;
    logic [PDATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PDATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [PDATA_WIDTH-1:0] right_hold_q, right_hold_d;
    logic                   frame_pend_q, frame_pend_d;
    logic [PDATA_WIDTH-1:0] pl_q, pl_d;
    logic [PDATA_WIDTH-1:0] pr_q, pr_d;
    logic                   pvalid_q, pvalid_d;
    logic                   boundary;
    logic [PDATA_WIDTH-1:0] word_cur;
`ifdef I2S_RX_FRAME_ERR_EN
    logic                   err_pend_q, err_pend_d;
    logic                   frame_err_q;
    logic                   len_bad;
`endif

    // State and datapath registers; async reset returns to power-up state.
    always_ff @(posedge sclk_in or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            lrck_d1_q    <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            left_hold_q  <= '0;
            right_hold_q <= '0;
            frame_pend_q <= 1'b0;
            pl_q         <= '0;
            pr_q         <= '0;
            pvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrck_d1_q    <= lrck_in;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            left_hold_q  <= left_hold_d;
            right_hold_q <= right_hold_d;
            frame_pend_q <= frame_pend_d;
            pl_q         <= pl_d;
            pr_q         <= pr_d;
            pvalid_q     <= pvalid_d;
        end
    end

    // Next-state: capture current bit, commit on LRCK boundaries, publish one edge later.
    always_comb begin
        boundary = (lrck_in != lrck_d1_q);
        // The bit on the boundary edge still belongs to the ending slot, so the
        // committed word includes it. Bits past PDATA_WIDTH shift out of the mask.
        word_cur = shift_q | (sdata_in ? (MSB_MASK >> cnt_q) : '0);

        state_d      = state_q;
        shift_d      = word_cur;
        cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        left_hold_d  = left_hold_q;
        right_hold_d = right_hold_q;
        frame_pend_d = 1'b0;
        pl_d         = pl_q;
        pr_d         = pr_q;
        pvalid_d     = 1'b0;

        if (frame_pend_q) begin
            pl_d     = left_hold_q;
            pr_d     = right_hold_q;
            pvalid_d = 1'b1;
        end

        // Data captured in WAIT_SYNC is harmless: the syncing boundary clears it.
        if (boundary) begin
            shift_d = '0;
            cnt_d   = '0;
            unique case (state_q)
                WAIT_SYNC: begin
                    if (!lrck_in) state_d = LEFT;
                end
                LEFT: begin
                    if (lrck_in) begin
                        left_hold_d = word_cur;
                        state_d     = RIGHT;
                    end
                end
                RIGHT: begin
                    if (!lrck_in) begin
                        right_hold_d = word_cur;
                        frame_pend_d = 1'b1;
                        state_d      = LEFT;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    // Slot length at the boundary is cnt_q+1; a saturated count is always wrong.
    always_comb begin
        len_bad    = (cnt_q != CNT_WIDTH'(PDATA_WIDTH - 1));
        err_pend_d = boundary && len_bad &&
                     (((state_q == LEFT) && lrck_in) || ((state_q == RIGHT) && !lrck_in));
    end

    // Delay the error by one edge so it lines up with the commit publish edge.
    always_ff @(posedge sclk_in or posedge rst) begin
        if (rst) begin
            err_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            err_pend_q  <= err_pend_d;
            frame_err_q <= err_pend_q;
        end
    end

    assign frame_err_out = frame_err_q;
`endif

    assign pldata_out = pl_q;
    assign prdata_out = pr_q;
    assign pvalid_out = pvalid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized stimulus with a slot-level reference model and a
// scoreboard monitor that checks every strobe and the hold value in between.
module tb_i2s_rx;

    localparam int W = 32;

    logic         sclk_in  = 1'b0;
    logic         rst      = 1'b1;
    logic         lrck_in  = 1'b1;
    logic         sdata_in = 1'b0;
    logic [W-1:0] pldata_out;
    logic [W-1:0] prdata_out;
    logic         pvalid_out;
`ifdef I2S_RX_FRAME_ERR_EN
    logic         frame_err_out;
`endif

    i2s_rx #(.PDATA_WIDTH(W)) dut (
        .sclk_in    (sclk_in),
        .rst        (rst),
        .lrck_in    (lrck_in),
        .sdata_in   (sdata_in),
        .pldata_out (pldata_out),
        .prdata_out (prdata_out),
        .pvalid_out (pvalid_out)
`ifdef I2S_RX_FRAME_ERR_EN
        ,
        .frame_err_out(frame_err_out)
`endif
    );

    always #5 sclk_in = ~sclk_in;

    int cyc = 0;
    always @(posedge sclk_in) cyc++;

    typedef struct {
        int           c;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } frame_t;

    frame_t       exp_q[$];
    int           err_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_l = '0;
    logic [W-1:0] last_r = '0;
    bit           synced = 1'b0;
    bit           have_left = 1'b0;
    logic [W-1:0] left_exp = '0;
    bit           prev_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A slot of length len is the first len bits of v (MSB first, left-justified);
    // anything past the word width is dropped, missing LSBs read as zero.
    function automatic logic [W-1:0] expect_word(input logic [63:0] v, input int len);
        logic [W-1:0] mask;
        mask = (len >= W) ? {W{1'b1}} : ~({W{1'b1}} >> len);
        return v[63 -: W] & mask;
    endfunction

    task automatic drive(input bit lr, input bit d);
        @(negedge sclk_in);
        lrck_in  = lr;
        sdata_in = d;
    endtask

    // Emit one slot of channel c. LRCK flips on the slot's last bit (I2S delay).
    // stop >= 0 abandons the slot after that many bits.
    task automatic emit_slot(input bit c, input logic [63:0] v, input int len, input int stop = -1);
        int  k;
        bit  d;
        frame_t e;
        for (int i = 0; i < len; i++) begin
            if (stop >= 0 && i == stop) return;
            if (i < 64) d = v[63-i];
            else        d = 1'($urandom);
            drive((i == len - 1) ? !c : c, d);
        end
        k = cyc;
        if (!c) begin
            if (synced) begin
                left_exp  = expect_word(v, len);
                have_left = 1'b1;
`ifdef I2S_RX_FRAME_ERR_EN
                if (len != W) err_q.push_back(k + 2);
`endif
            end
        end else begin
            if (synced && have_left) begin
                e.c = k + 2;
                e.l = left_exp;
                e.r = expect_word(v, len);
                exp_q.push_back(e);
`ifdef I2S_RX_FRAME_ERR_EN
                if (len != W) err_q.push_back(k + 2);
`endif
            end
            synced    = 1'b1;
            have_left = 1'b0;
        end
    endtask

    task automatic emit_frame(input logic [63:0] l, input int ll, input logic [63:0] r, input int rl);
        emit_slot(1'b0, l, ll);
        emit_slot(1'b1, r, rl);
    endtask

    task automatic do_reset();
        @(negedge sclk_in);
        #2 rst = 1'b1;
        #1;
        check("rst_pl", pldata_out, '0);
        check("rst_pr", prdata_out, '0);
        check("rst_pvalid", pvalid_out, 1'b0);
        synced    = 1'b0;
        have_left = 1'b0;
        last_l    = '0;
        last_r    = '0;
        exp_q.delete();
        err_q.delete();
        repeat (3) @(negedge sclk_in);
        #2 rst = 1'b0;
    endtask

    // Scoreboard monitor: pops an expected frame per strobe, otherwise checks hold.
    always @(negedge sclk_in) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (pvalid_out) begin
                check("no_back_to_back", 64'(prev_v), 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got pvalid at cycle %0d want none", cyc);
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    check("strobe_cycle", 64'(cyc), 64'(e.c));
                    check("left_word", 64'(pldata_out), 64'(e.l));
                    check("right_word", 64'(prdata_out), 64'(e.r));
                    last_l = e.l;
                    last_r = e.r;
                end
            end else begin
                check("hold_left", 64'(pldata_out), 64'(last_l));
                check("hold_right", 64'(prdata_out), 64'(last_r));
            end
            prev_v = pvalid_out;
`ifdef I2S_RX_FRAME_ERR_EN
            if (frame_err_out) begin
                if (err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_err: got pulse at cycle %0d want none", cyc);
                end else begin
                    check("frame_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
                end
            end
`endif
        end
    end

    initial begin
        int len_l, len_r;
        rst      = 1'b1;
        lrck_in  = 1'b1;
        sdata_in = 1'b0;
        repeat (2) @(negedge sclk_in);
        #1;
        check("por_pl", pldata_out, '0);
        check("por_pr", prdata_out, '0);
        check("por_pvalid", pvalid_out, 1'b0);
        @(negedge sclk_in);
        #2 rst = 1'b0;

        // Start mid right slot: partial slot only provides sync.
        emit_slot(1'b1, {$urandom, 32'h0}, 13);

        // Nominal frames.
        emit_frame({32'hA5A50001, 32'h0}, 32, {32'h12345678, 32'h0}, 32);
        emit_frame({32'hFFFFFFFF, 32'h0}, 32, {32'h00000000, 32'h0}, 32);

        // Short 24-bit slots.
        emit_frame({24'hABCDEF, 40'h0}, 24, {24'h123456, 40'h0}, 24);

        // Long 40-bit slots.
        emit_frame({40'hDEADBEEF55, 24'h0}, 40, {40'hCAFEF00DAA, 24'h0}, 40);

        // Very long left slot: counter must saturate, not wrap.
        emit_frame({$urandom, $urandom}, 300, {$urandom, 32'h0}, 32);

        // One-cycle slots.
        emit_frame({1'b1, 63'h0}, 1, {1'b1, 63'h0}, 1);
        emit_frame({1'b0, 63'h0}, 1, {1'b1, 63'h0}, 1);
        emit_frame({32'h0F0F0F0F, 32'h0}, 32, {1'b1, 63'h0}, 1);

        // Reset mid right slot after a good frame.
        emit_frame({$urandom, 32'h0}, 32, {$urandom, 32'h0}, 32);
        emit_slot(1'b0, {$urandom, 32'h0}, 32);
        emit_slot(1'b1, {$urandom, 32'h0}, 32, 10);
        do_reset();
        emit_slot(1'b1, {$urandom, 32'h0}, 20);
        emit_frame({$urandom, 32'h0}, 32, {$urandom, 32'h0}, 32);

        // Random slot lengths, including single-bit and long slots.
        for (int f = 0; f < 20; f++) begin
            len_l = $urandom_range(1, 40);
            len_r = $urandom_range(1, 40);
            emit_frame({$urandom, $urandom}, len_l, {$urandom, $urandom}, len_r);
        end

        // Loopback-style stream of random nominal frames.
        for (int f = 0; f < 1000; f++) begin
            emit_frame({$urandom, 32'h0}, W, {$urandom, 32'h0}, W);
        end

        for (int i = 0; i < 10 && (exp_q.size() != 0 || err_q.size() != 0); i++) begin
            @(negedge sclk_in);
        end
        repeat (2) @(negedge sclk_in);
        check("drain_frames", 64'(exp_q.size()), 64'd0);
`ifdef I2S_RX_FRAME_ERR_EN
        check("drain_frame_err", 64'(err_q.size()), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
